// File: rtl/tdc_sampler.sv
// Self-timed TDC measurement engine: launches edges into a tapped delay line,
// thermometer-decodes each capture and accumulates 2^SAMPLE_LOG2 samples per request.

module delay_line #(
    parameter int N       = 64,
    parameter     DL_TYPE = "RCA"
) (
    input  logic         din,
    output logic [N-1:0] dl_out
);

    generate
        if (DL_TYPE == "RCA") begin : g_rca
            // Carry chain of an adder with A = all ones, B = 0: the carry-in ripples tap by tap.
            localparam logic [N-1:0] OPA = '1;
            localparam logic [N-1:0] OPB = '0;
            logic [N:0] w_carry;

            assign w_carry[0] = din;
            for (genvar i = 0; i < N; i++) begin : g_stage
                assign w_carry[i+1] = (OPA[i] & OPB[i]) | ((OPA[i] ^ OPB[i]) & w_carry[i]);
            end
            assign dl_out = w_carry[N:1];
        end else begin : g_buf
            logic [N:0] w_chain;

            assign w_chain[0] = din;
            for (genvar i = 0; i < N; i++) begin : g_stage
                assign w_chain[i+1] = w_chain[i];
            end
            assign dl_out = w_chain[N:1];
        end
    endgenerate

endmodule

module tdc_sampler #(
    parameter int N           = 64,
    parameter     DL_TYPE     = "RCA",
    parameter int SAMPLE_LOG2 = 0,
    parameter int RELAX_CYC   = 1,
    parameter int CW          = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    output logic                      busy,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [CW+SAMPLE_LOG2-1:0] result,
    output logic                      overflow,
    output logic                      underflow,
    output logic [N-1:0]              raw_therm
);

    localparam int RW  = CW + SAMPLE_LOG2;
    localparam int SCW = SAMPLE_LOG2 + 1;
    localparam int RCW = (RELAX_CYC > 1) ? $clog2(RELAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SYNC,
        ENCODE,
        RELAX,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic           r_launchQ;
    logic           r_polQ;
    logic [N-1:0]   r_cap1;
    logic [N-1:0]   r_cap2;
    logic [RW-1:0]  r_acc;
    logic [SCW-1:0] r_sampCnt;
    logic [RCW-1:0] r_relaxCnt;

    logic [N-1:0]   w_dlOut;
    logic [N-1:0]   w_therm;
    logic [CW-1:0]  w_count;
    logic           w_relaxDone;
    logic           w_lastSample;

    delay_line #(
        .N       (N),
        .DL_TYPE (DL_TYPE)
    ) u_dl (
        .din    (r_launchQ ^ r_polQ),
        .dl_out (w_dlOut)
    );

    // Free-running two-flop capture; the taps are asynchronous to clk.
    always_ff @(posedge clk) begin
        r_cap1 <= w_dlOut;
        r_cap2 <= r_cap1;
    end

    assign w_therm      = r_cap2 ^ {N{r_polQ}};
    assign w_relaxDone  = (r_relaxCnt == RCW'(RELAX_CYC - 1));
    assign w_lastSample = (r_sampCnt == SCW'((1 << SAMPLE_LOG2) - 1));

    // First-zero encoding: bubbles above the first zero are ignored.
    always_comb begin
        w_count = CW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (!w_therm[i]) begin
                w_count = CW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = ARM;
            ARM:     w_nextState = FIRE;
            FIRE:    w_nextState = SYNC;
            SYNC:    w_nextState = ENCODE;
            ENCODE:  w_nextState = RELAX;
            RELAX: begin
                if (w_relaxDone) begin
                    w_nextState = w_lastSample ? DONE : FIRE;
                end
            end
            DONE:    if (result_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        result_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_launchQ  <= 1'b0;
            r_polQ     <= 1'b0;
            r_acc      <= '0;
            r_sampCnt  <= '0;
            r_relaxCnt <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            raw_therm  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_polQ    <= mode;
                        r_acc     <= '0;
                        r_sampCnt <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                ARM: begin
                    r_launchQ <= 1'b1;
                end
                FIRE: begin
                    r_launchQ <= 1'b0;
                end
                ENCODE: begin
                    r_acc      <= r_acc + RW'(w_count);
                    overflow   <= overflow | (w_count == CW'(N));
                    underflow  <= underflow | (w_count == '0);
                    raw_therm  <= w_therm;
                    r_relaxCnt <= '0;
                end
                RELAX: begin
                    if (!w_relaxDone) begin
                        r_relaxCnt <= r_relaxCnt + 1'b1;
                    end else if (w_lastSample) begin
                        result <= r_acc;
                    end else begin
                        r_sampCnt <= r_sampCnt + 1'b1;
                        r_launchQ <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_sampler.sv
// Directed bench for tdc_sampler: a default instance plus a 4-sample averaging instance,
// with expected results queued at stimulus time and popped when result_valid rises.

module tb_tdc_sampler;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        startA = 1'b0, modeA = 1'b0, readyA = 1'b0;
    logic        busyA, validA, ovA, unA;
    logic [6:0]  resultA;
    logic [N-1:0] rawA;

    logic        startB = 1'b0, modeB = 1'b0, readyB = 1'b0;
    logic        busyB, validB, ovB, unB;
    logic [8:0]  resultB;
    logic [N-1:0] rawB;

    tdc_sampler #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (startA),
        .mode         (modeA),
        .busy         (busyA),
        .result_valid (validA),
        .result_ready (readyA),
        .result       (resultA),
        .overflow     (ovA),
        .underflow    (unA),
        .raw_therm    (rawA)
    );

    tdc_sampler #(.N(N), .SAMPLE_LOG2(2)) dutAvg (
        .clk          (clk),
        .rst          (rst),
        .start        (startB),
        .mode         (modeB),
        .busy         (busyB),
        .result_valid (validB),
        .result_ready (readyB),
        .result       (resultB),
        .overflow     (ovB),
        .underflow    (unB),
        .raw_therm    (rawB)
    );

    typedef struct {
        logic [63:0] result;
        logic        ov;
        logic        un;
        logic [63:0] raw;
        int          latency;
    } exp_t;

    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;
    logic useAvg = 1'b0;

    logic        obsValid, obsBusy, obsOv, obsUn;
    logic [63:0] obsResult, obsRaw;

    always_comb begin
        obsValid  = useAvg ? validB : validA;
        obsBusy   = useAvg ? busyB : busyA;
        obsOv     = useAvg ? ovB : ovA;
        obsUn     = useAvg ? unB : unA;
        obsResult = useAvg ? 64'(resultB) : 64'(resultA);
        obsRaw    = useAvg ? rawB : rawA;
    end

    // Launch pulse monitor for the averaging instance.
    logic avgCountEn = 1'b0;
    logic prevLaunchB = 1'b0;
    int   avgPulses = 0;
    int   avgHigh = 0;
    always @(posedge clk) begin
        if (!avgCountEn) begin
            avgPulses = 0;
            avgHigh   = 0;
        end else begin
            if (dutAvg.r_launchQ) avgHigh++;
            if (dutAvg.r_launchQ && !prevLaunchB) avgPulses++;
        end
        prevLaunchB = dutAvg.r_launchQ;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic m, input logic [63:0] eRes,
                                 input logic eOv, input logic eUn, input logic [63:0] eRaw,
                                 input int eLat);
        exp_t e;
        e.result  = eRes;
        e.ov      = eOv;
        e.un      = eUn;
        e.raw     = eRaw;
        e.latency = eLat;
        sbQueue.push_back(e);
        useAvg = sel;
        if (sel) begin
            startB = 1'b1;
            modeB  = m;
        end else begin
            startA = 1'b1;
            modeA  = m;
        end
        tick();
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic checkResult(input string tag);
        int   edges = 0;
        exp_t e;
        while (!obsValid && edges < 200) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_valid"}, 64'(obsValid), 64'd1);
        checks++;
        assert (sbQueue.size() > 0) else begin
            errors++;
            $error("[TB] FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput({tag, "_latency"}, 64'(edges), 64'(e.latency));
            checkOutput({tag, "_result"}, obsResult, e.result);
            checkOutput({tag, "_overflow"}, 64'(obsOv), 64'(e.ov));
            checkOutput({tag, "_underflow"}, 64'(obsUn), 64'(e.un));
            checkOutput({tag, "_raw"}, obsRaw, e.raw);
        end
    endtask

    task automatic acceptResult(input string tag);
        if (useAvg) readyB = 1'b1;
        else        readyA = 1'b1;
        tick();
        readyA = 1'b0;
        readyB = 1'b0;
        checkOutput({tag, "_busy_after_ready"}, 64'(obsBusy), 64'd0);
        checkOutput({tag, "_valid_after_ready"}, 64'(obsValid), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_busy", 64'(busyA), 64'd0);
        checkOutput("reset_valid", 64'(validA), 64'd0);
        checkOutput("reset_result", 64'(resultA), 64'd0);
        checkOutput("reset_raw", 64'(rawA), 64'd0);
        checkOutput("reset_flags", 64'({ovA, unA}), 64'd0);

        applyStimulus(1'b0, 1'b0, 64'd64, 1'b1, 1'b0, {64{1'b1}}, 5);
        checkResult("rise_zero_delay");
        acceptResult("rise_zero_delay");

        force dut.w_dlOut = 64'h00000000000000F7;
        applyStimulus(1'b0, 1'b0, 64'd3, 1'b0, 1'b0, 64'h00000000000000F7, 5);
        checkResult("bubble_f7");
        acceptResult("bubble_f7");

        force dut.w_dlOut = 64'h00000000000000FF;
        applyStimulus(1'b0, 1'b0, 64'd8, 1'b0, 1'b0, 64'h00000000000000FF, 5);
        checkResult("bubble_ff");
        acceptResult("bubble_ff");

        force dut.w_dlOut = 64'hFFFFFFFFFFFFFF00;
        applyStimulus(1'b0, 1'b1, 64'd8, 1'b0, 1'b0, 64'h00000000000000FF, 5);
        checkResult("fall_ff00");
        acceptResult("fall_ff00");

        force dut.w_dlOut = {64{1'b1}};
        applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 64'd0, 5);
        checkResult("fall_all_ones");
        acceptResult("fall_all_ones");

        release dut.w_dlOut;
        applyStimulus(1'b0, 1'b1, 64'd64, 1'b1, 1'b0, {64{1'b1}}, 5);
        checkResult("fall_zero_delay");
        acceptResult("fall_zero_delay");

        // Reset while the edge is in flight.
        startA = 1'b1;
        modeA  = 1'b0;
        tick();
        startA = 1'b0;
        tick();
        checkOutput("midfire_launch", 64'(dut.r_launchQ), 64'd1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("midreset_busy", 64'(busyA), 64'd0);
        checkOutput("midreset_valid", 64'(validA), 64'd0);
        checkOutput("midreset_result", 64'(resultA), 64'd0);
        checkOutput("midreset_launch", 64'(dut.r_launchQ), 64'd0);
        applyStimulus(1'b0, 1'b0, 64'd64, 1'b1, 1'b0, {64{1'b1}}, 5);
        checkResult("after_reset");

        // Backpressure: DONE must hold and ignore start.
        for (int i = 0; i < 10; i++) begin
            startA = (i % 2 == 0);
            tick();
            checkOutput("bp_valid", 64'(validA), 64'd1);
            checkOutput("bp_result", 64'(resultA), 64'd64);
            checkOutput("bp_launch", 64'(dut.r_launchQ), 64'd0);
        end
        startA = 1'b1;
        readyA = 1'b1;
        tick();
        startA = 1'b0;
        readyA = 1'b0;
        checkOutput("bp_release_busy", 64'(busyA), 64'd0);
        tick();
        checkOutput("bp_no_restart", 64'(busyA), 64'd0);

        force dutAvg.w_dlOut = 64'h0000000000001FFF;
        avgCountEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'd52, 1'b0, 1'b0, 64'h0000000000001FFF, 17);
        checkResult("avg_13");
        checkOutput("avg_pulses", 64'(avgPulses), 64'd4);
        checkOutput("avg_launch_cycles", 64'(avgHigh), 64'd4);
        avgCountEn = 1'b0;
        acceptResult("avg_13");
        release dutAvg.w_dlOut;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
